// File: rtl/datapath_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | datapath_pkg                                                         |
// | Control, stage-register and helper definitions for datapath_pipe.    |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package datapath_pkg;

    // Instruction register fields are 5 bits; narrower files mask them.
    localparam int c_REG_FIELD_W = 5;

    typedef logic [c_REG_FIELD_W-1:0] reg_idx_t;

    typedef enum logic [1:0] {
        ADD = 2'b00,
        SUB = 2'b01,
        AND = 2'b10,
        OR  = 2'b11
    } alu_op_e;

    typedef struct packed {
        logic    regdst;
        logic    regwr;
        logic    alusrc;
        alu_op_e aluop;
        logic    memwr;
        logic    memtoreg;
    } ctrl_t;

    typedef struct packed {
        logic     valid;
        logic     regwr;
        logic     alusrc;
        alu_op_e  aluop;
        logic     memwr;
        logic     memtoreg;
        reg_idx_t rs;
        reg_idx_t rt;
        reg_idx_t dst;
    } id_ex_t;

    typedef struct packed {
        logic     valid;
        logic     regwr;
        logic     memwr;
        logic     memtoreg;
        reg_idx_t dst;
    } ex_mem_t;

    typedef struct packed {
        logic     valid;
        logic     regwr;
        reg_idx_t dst;
    } mem_wb_t;

    function automatic logic reg_hit(input logic wr, input reg_idx_t dst, input reg_idx_t src);
        return wr && (dst == src);
    endfunction

endpackage
`default_nettype wire

// File: rtl/datapath_pipe_regfile.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | regfile_bypass                                                       |
// | NREGS x WIDTH register file, 2R/1W, write-through to both reads.     |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module regfile_bypass #(
    parameter int WIDTH = 32,
    parameter int NREGS = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_we,
    input  logic [$clog2(NREGS)-1:0] i_waddr,
    input  logic [WIDTH-1:0]         i_wdata,
    input  logic [$clog2(NREGS)-1:0] i_raddr_a,
    input  logic [$clog2(NREGS)-1:0] i_raddr_b,
    output logic [WIDTH-1:0]         o_rdata_a,
    output logic [WIDTH-1:0]         o_rdata_b
);

    logic [WIDTH-1:0] w_regs [NREGS];
    logic             w_we_live;

    assign w_we_live = i_we && (i_waddr != '0);

    for (genvar gi = 0; gi < NREGS; gi++) begin : g_reg
        if (gi == 0) begin : g_zero
            assign w_regs[gi] = '0;
        end else begin : g_word
            logic [WIDTH-1:0] r_q;
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_q <= '0;
                end else if (i_we && (int'(i_waddr) == gi)) begin
                    r_q <= i_wdata;
                end
            end
            assign w_regs[gi] = r_q;
        end
    end

    // Same-cycle write returns the new value to the reader.
    assign o_rdata_a = (w_we_live && (i_waddr == i_raddr_a)) ? i_wdata : w_regs[i_raddr_a];
    assign o_rdata_b = (w_we_live && (i_waddr == i_raddr_b)) ? i_wdata : w_regs[i_raddr_b];

endmodule
`default_nettype wire

// File: rtl/datapath_pipe.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | datapath_pipe                                                        |
// | Five-stage MIPS datapath with internal forwarding and stall control. |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module datapath_pipe
    import datapath_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter int NREGS      = 32,
    parameter int DMEM_DEPTH = 64,
    parameter int FORWARD    = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [31:0]              Instructions,
    input  logic                     RegDst,
    input  logic                     RegWr,
    input  logic                     ALUsrc,
    input  logic                     MemWr,
    input  logic                     MemToReg,
    input  logic [1:0]               ALUcntrl,
    output logic [WIDTH-1:0]         reg_Da,
    output logic [WIDTH-1:0]         seOut,
    output logic                     Zero,
    output logic                     wb_valid,
    output logic [$clog2(NREGS)-1:0] wb_addr,
    output logic [WIDTH-1:0]         wb_data
);

    localparam int       c_AW       = $clog2(NREGS);
    localparam int       c_DA       = $clog2(DMEM_DEPTH);
    localparam reg_idx_t c_REG_MASK = reg_idx_t'(NREGS - 1);

    // ---------------- decode of the presented instruction ----------------
    ctrl_t            w_ctrl;
    reg_idx_t         w_rs, w_rt, w_rd, w_dst;
    logic             w_regwr, w_use_rt, w_stall, w_accept;
    logic [c_AW-1:0]  w_rs_a, w_rt_a;
    logic [WIDTH-1:0] w_rt_data;
    logic             w_unused;

    assign w_ctrl = '{regdst: RegDst, regwr: RegWr, alusrc: ALUsrc,
                      aluop: alu_op_e'(ALUcntrl), memwr: MemWr, memtoreg: MemToReg};

    assign w_rs     = Instructions[25:21] & c_REG_MASK;
    assign w_rt     = Instructions[20:16] & c_REG_MASK;
    assign w_rd     = Instructions[15:11] & c_REG_MASK;
    assign w_dst    = w_ctrl.regdst ? w_rd : w_rt;
    // A $0 destination is folded away here so nothing downstream sees it.
    assign w_regwr  = w_ctrl.regwr && (w_dst != '0);
    assign w_use_rt = !w_ctrl.alusrc || w_ctrl.memwr;
    assign w_rs_a   = c_AW'(w_rs);
    assign w_rt_a   = c_AW'(w_rt);
    assign seOut    = WIDTH'($signed(Instructions[15:0]));
    assign w_unused = ^Instructions[31:26];

    assign in_ready = !w_stall;
    assign w_accept = in_valid && in_ready;

    // ---------------- pipeline state ----------------
    id_ex_t           r_id_ex;
    ex_mem_t          r_ex_mem;
    mem_wb_t          r_mem_wb;
    logic [WIDTH-1:0] r_id_ex_a, r_id_ex_b, r_id_ex_imm;
    logic [WIDTH-1:0] r_ex_mem_alu, r_ex_mem_sd, r_mem_wb_data;
    logic             r_zero;
    logic [WIDTH-1:0] r_dmem [DMEM_DEPTH];

    logic [WIDTH-1:0] w_fwd_a, w_fwd_b, w_op_b, w_alu, w_load;
    logic [c_DA-1:0]  w_mem_idx;
    logic             w_exmem_wr, w_hit_idex;

    assign wb_valid   = r_mem_wb.valid && r_mem_wb.regwr;
    assign wb_addr    = c_AW'(r_mem_wb.dst);
    assign wb_data    = r_mem_wb_data;
    assign Zero       = r_zero;
    assign w_exmem_wr = r_ex_mem.valid && r_ex_mem.regwr;

    regfile_bypass #(
        .WIDTH (WIDTH),
        .NREGS (NREGS)
    ) u_regfile (
        .clk       (clk),
        .rst       (rst),
        .i_we      (wb_valid),
        .i_waddr   (wb_addr),
        .i_wdata   (wb_data),
        .i_raddr_a (w_rs_a),
        .i_raddr_b (w_rt_a),
        .o_rdata_a (reg_Da),
        .o_rdata_b (w_rt_data)
    );

    assign w_hit_idex = reg_hit(r_id_ex.valid && r_id_ex.regwr, r_id_ex.dst, w_rs) ||
                        (w_use_rt && reg_hit(r_id_ex.valid && r_id_ex.regwr, r_id_ex.dst, w_rt));

    if (FORWARD != 0) begin : g_fwd
        // Only a load still in EX cannot be bypassed in time.
        assign w_stall = r_id_ex.memtoreg && w_hit_idex;
        assign w_fwd_a = reg_hit(w_exmem_wr, r_ex_mem.dst, r_id_ex.rs) ? r_ex_mem_alu  :
                         reg_hit(wb_valid,   r_mem_wb.dst, r_id_ex.rs) ? r_mem_wb_data :
                                                                          r_id_ex_a;
        assign w_fwd_b = reg_hit(w_exmem_wr, r_ex_mem.dst, r_id_ex.rt) ? r_ex_mem_alu  :
                         reg_hit(wb_valid,   r_mem_wb.dst, r_id_ex.rt) ? r_mem_wb_data :
                                                                          r_id_ex_b;
    end else begin : g_stall
        // Hold in ID until the producer reaches MEM/WB and the regfile bypass covers it.
        logic w_hit_exmem;
        logic w_unused_fwd;
        assign w_hit_exmem  = reg_hit(w_exmem_wr, r_ex_mem.dst, w_rs) ||
                              (w_use_rt && reg_hit(w_exmem_wr, r_ex_mem.dst, w_rt));
        assign w_stall      = w_hit_idex || w_hit_exmem;
        assign w_fwd_a      = r_id_ex_a;
        assign w_fwd_b      = r_id_ex_b;
        assign w_unused_fwd = ^{r_id_ex.rs, r_id_ex.rt};
    end

    assign w_op_b = r_id_ex.alusrc ? r_id_ex_imm : w_fwd_b;

    always_comb begin
        w_alu = '0;
        case (r_id_ex.aluop)
            ADD:     w_alu = w_fwd_a + w_op_b;
            SUB:     w_alu = w_fwd_a - w_op_b;
            AND:     w_alu = w_fwd_a & w_op_b;
            OR:      w_alu = w_fwd_a | w_op_b;
            default: w_alu = '0;
        endcase
    end

    assign w_mem_idx = r_ex_mem_alu[c_DA+1:2];
    assign w_load    = r_dmem[w_mem_idx];

    always_ff @(posedge clk) begin
        if (!rst && r_ex_mem.valid && r_ex_mem.memwr) begin
            r_dmem[w_mem_idx] <= r_ex_mem_sd;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_id_ex       <= '0;
            r_ex_mem      <= '0;
            r_mem_wb      <= '0;
            r_id_ex_a     <= '0;
            r_id_ex_b     <= '0;
            r_id_ex_imm   <= '0;
            r_ex_mem_alu  <= '0;
            r_ex_mem_sd   <= '0;
            r_mem_wb_data <= '0;
            r_zero        <= 1'b0;
        end else begin
            if (w_accept) begin
                r_id_ex <= '{valid: 1'b1, regwr: w_regwr, alusrc: w_ctrl.alusrc,
                             aluop: w_ctrl.aluop, memwr: w_ctrl.memwr,
                             memtoreg: w_ctrl.memtoreg && w_regwr,
                             rs: w_rs, rt: w_rt, dst: w_dst};
            end else begin
                r_id_ex <= '0;
            end
            r_id_ex_a     <= reg_Da;
            r_id_ex_b     <= w_rt_data;
            r_id_ex_imm   <= seOut;
            r_ex_mem      <= '{valid: r_id_ex.valid, regwr: r_id_ex.regwr,
                               memwr: r_id_ex.memwr, memtoreg: r_id_ex.memtoreg,
                               dst: r_id_ex.dst};
            r_ex_mem_alu  <= w_alu;
            r_ex_mem_sd   <= w_fwd_b;
            r_zero        <= r_id_ex.valid && (w_alu == '0);
            r_mem_wb      <= '{valid: r_ex_mem.valid, regwr: r_ex_mem.regwr, dst: r_ex_mem.dst};
            r_mem_wb_data <= r_ex_mem.memtoreg ? w_load : r_ex_mem_alu;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_datapath_pipe.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_datapath_pipe                                                     |
// | Scoreboard bench for datapath_pipe with FORWARD=1 and FORWARD=0.     |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_datapath_pipe;

    // {regdst, regwr, alusrc, memwr, memtoreg, aluop[1:0]}
    localparam logic [6:0] c_ADDI = 7'b0110000;
    localparam logic [6:0] c_ADD  = 7'b1100000;
    localparam logic [6:0] c_SUB  = 7'b1100001;
    localparam logic [6:0] c_LW   = 7'b0110100;
    localparam logic [6:0] c_SW   = 7'b0011000;

    logic        clk = 1'b0;
    logic        rst, in_valid, sel0;
    logic [31:0] instr;
    logic        regdst, regwr, alusrc, memwr, memtoreg;
    logic [1:0]  alucntrl;

    logic        rdy1, rdy0, zero1, zero0, wbv1, wbv0;
    logic [4:0]  wba1, wba0;
    logic [31:0] da1, da0, se1, se0, wbd1, wbd0;

    logic        cur_rdy, cur_zero, cur_wbv;
    logic [4:0]  cur_wba;
    logic [31:0] cur_da, cur_se, cur_wbd;

    int          checks = 0;
    int          failures = 0;
    logic [31:0] exp_rf [32];
    logic [31:0] exp_mem [64];
    logic [36:0] exp_q [$];
    logic [36:0] got_q [$];

    always #5 clk = ~clk;

    assign cur_rdy  = sel0 ? rdy0  : rdy1;
    assign cur_zero = sel0 ? zero0 : zero1;
    assign cur_wbv  = sel0 ? wbv0  : wbv1;
    assign cur_wba  = sel0 ? wba0  : wba1;
    assign cur_da   = sel0 ? da0   : da1;
    assign cur_se   = sel0 ? se0   : se1;
    assign cur_wbd  = sel0 ? wbd0  : wbd1;

    datapath_pipe #(.WIDTH(32), .NREGS(32), .DMEM_DEPTH(64), .FORWARD(1)) u_dut (
        .clk(clk), .rst(rst), .in_valid(in_valid && !sel0), .in_ready(rdy1),
        .Instructions(instr), .RegDst(regdst), .RegWr(regwr), .ALUsrc(alusrc),
        .MemWr(memwr), .MemToReg(memtoreg), .ALUcntrl(alucntrl),
        .reg_Da(da1), .seOut(se1), .Zero(zero1),
        .wb_valid(wbv1), .wb_addr(wba1), .wb_data(wbd1)
    );

    datapath_pipe #(.WIDTH(32), .NREGS(32), .DMEM_DEPTH(64), .FORWARD(0)) u_dut0 (
        .clk(clk), .rst(rst), .in_valid(in_valid && sel0), .in_ready(rdy0),
        .Instructions(instr), .RegDst(regdst), .RegWr(regwr), .ALUsrc(alusrc),
        .MemWr(memwr), .MemToReg(memtoreg), .ALUcntrl(alucntrl),
        .reg_Da(da0), .seOut(se0), .Zero(zero0),
        .wb_valid(wbv0), .wb_addr(wba0), .wb_data(wbd0)
    );

    // Collects every write-back the selected DUT produces.
    always @(negedge clk) begin
        if (!rst && cur_wbv) got_q.push_back({cur_wba, cur_wbd});
    end

    function automatic logic [31:0] i_type(input logic [4:0] rs, input logic [4:0] rt,
                                           input logic [15:0] imm);
        return {6'b001000, rs, rt, imm};
    endfunction

    function automatic logic [31:0] r_type(input logic [4:0] rs, input logic [4:0] rt,
                                           input logic [4:0] rd);
        return {6'b000000, rs, rt, rd, 11'd0};
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 32; i++) exp_rf[i] = '0;
        exp_q.delete();
        got_q.delete();
    endtask

    // Sequential ISA-level execution of one accepted instruction.
    task automatic model_exec(input logic [31:0] ins, input logic [6:0] c);
        logic [4:0]  rs, rt, rd, dst;
        logic [15:0] imm;
        logic [31:0] a, b, se, alu, res;
        rs  = ins[25:21];
        rt  = ins[20:16];
        rd  = ins[15:11];
        imm = ins[15:0];
        se  = {{16{imm[15]}}, imm};
        a   = exp_rf[rs];
        b   = c[4] ? se : exp_rf[rt];
        case (c[1:0])
            2'b00:   alu = a + b;
            2'b01:   alu = a - b;
            2'b10:   alu = a & b;
            default: alu = a | b;
        endcase
        if (c[3]) exp_mem[alu[7:2]] = exp_rf[rt];
        res = c[2] ? exp_mem[alu[7:2]] : alu;
        dst = c[6] ? rd : rt;
        if (c[5] && dst != 5'd0) begin
            exp_rf[dst] = res;
            exp_q.push_back({dst, res});
        end
    endtask

    // Presents an instruction from a negedge and returns at the negedge after acceptance.
    task automatic issue(input logic [31:0] ins, input logic [6:0] c, output int stalls);
        stalls = 0;
        instr = ins;
        {regdst, regwr, alusrc, memwr, memtoreg, alucntrl} = c;
        in_valid = 1'b1;
        #1;
        while (!cur_rdy && stalls < 10) begin
            stalls++;
            @(negedge clk);
            #1;
        end
        if (cur_rdy) begin
            @(posedge clk);
            model_exec(ins, c);
            @(negedge clk);
        end else begin
            stalls = 99;
            in_valid = 1'b0;
        end
    endtask

    task automatic settle();
        in_valid = 1'b0;
        repeat (6) @(negedge clk);
    endtask

    task automatic apply_reset();
        in_valid = 1'b0;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        model_clear();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        in_valid = 1'b0;
        instr = i_type(5'd1, 5'd0, 16'hFFFF);
        {regdst, regwr, alusrc, memwr, memtoreg, alucntrl} = c_ADDI;
        @(negedge clk);
        checks++; if (cur_rdy !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", cur_rdy); end
        checks++; if (cur_wbv !== 1'b0) begin failures++; $display("FAIL reset_wb_valid got=%b exp=0", cur_wbv); end
        checks++; if (cur_wba !== 5'd0) begin failures++; $display("FAIL reset_wb_addr got=%0d exp=0", cur_wba); end
        checks++; if (cur_wbd !== 32'd0) begin failures++; $display("FAIL reset_wb_data got=%0d exp=0", cur_wbd); end
        checks++; if (cur_zero !== 1'b0) begin failures++; $display("FAIL reset_zero got=%b exp=0", cur_zero); end
        checks++; if (cur_da !== 32'd0) begin failures++; $display("FAIL reset_reg_da got=%0d exp=0", cur_da); end
        checks++; if (cur_se !== 32'hFFFF_FFFF) begin failures++; $display("FAIL sign_extend got=%h exp=ffffffff", cur_se); end
        rst = 1'b0;
        model_clear();
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        int s;
        logic [36:0] e, g;
        issue(i_type(5'd0, 5'd1, 16'd2015), c_ADDI, s);
        checks++; if (s !== 0) begin failures++; $display("FAIL b2b_ready0 stalls=%0d exp=0", s); end
        issue(i_type(5'd0, 5'd2, 16'd404), c_ADDI, s);
        checks++; if (s !== 0) begin failures++; $display("FAIL b2b_ready1 stalls=%0d exp=0", s); end
        issue(r_type(5'd1, 5'd2, 5'd1), c_ADD, s);
        checks++; if (s !== 0) begin failures++; $display("FAIL b2b_ready2 stalls=%0d exp=0", s); end
        settle();
        checks++;
        if (got_q.size() != exp_q.size()) begin failures++; $display("FAIL b2b_count got=%0d exp=%0d", got_q.size(), exp_q.size()); end
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            e = exp_q.pop_front(); g = got_q.pop_front(); checks++;
            if (g !== e) begin failures++; $display("FAIL b2b_wb got=%0d:%0d exp=%0d:%0d", g[36:32], g[31:0], e[36:32], e[31:0]); end
        end
        exp_q.delete(); got_q.delete();
    endtask

    task automatic test_store_forward();
        int s;
        logic [36:0] e, g;
        issue(i_type(5'd0, 5'd2, 16'd77), c_ADDI, s);
        issue(i_type(5'd0, 5'd2, 16'd404), c_ADDI, s);
        issue(i_type(5'd0, 5'd2, 16'd0), c_SW, s);
        checks++; if (s !== 0) begin failures++; $display("FAIL sw_stall stalls=%0d exp=0", s); end
        issue(i_type(5'd0, 5'd3, 16'd0), c_LW, s);
        checks++; if (s !== 0) begin failures++; $display("FAIL lw_stall stalls=%0d exp=0", s); end
        settle();
        checks++;
        if (got_q.size() != exp_q.size()) begin failures++; $display("FAIL stfwd_count got=%0d exp=%0d", got_q.size(), exp_q.size()); end
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            e = exp_q.pop_front(); g = got_q.pop_front(); checks++;
            if (g !== e) begin failures++; $display("FAIL stfwd_wb got=%0d:%0d exp=%0d:%0d", g[36:32], g[31:0], e[36:32], e[31:0]); end
        end
        exp_q.delete(); got_q.delete();
    endtask

    task automatic test_load_use();
        int s;
        logic [36:0] e, g;
        issue(i_type(5'd0, 5'd3, 16'd0), c_LW, s);
        issue(r_type(5'd3, 5'd3, 5'd4), c_ADD, s);
        checks++; if (s !== 1) begin failures++; $display("FAIL load_use_stall stalls=%0d exp=1", s); end
        settle();
        checks++;
        if (got_q.size() != exp_q.size()) begin failures++; $display("FAIL ldu_count got=%0d exp=%0d", got_q.size(), exp_q.size()); end
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            e = exp_q.pop_front(); g = got_q.pop_front(); checks++;
            if (g !== e) begin failures++; $display("FAIL ldu_wb got=%0d:%0d exp=%0d:%0d", g[36:32], g[31:0], e[36:32], e[31:0]); end
        end
        exp_q.delete(); got_q.delete();
    endtask

    task automatic test_zero_r0();
        int s;
        logic [36:0] e, g;
        issue(i_type(5'd0, 5'd5, 16'd5), c_ADDI, s);
        issue(r_type(5'd5, 5'd5, 5'd6), c_SUB, s);
        checks++; if (cur_zero !== 1'b0) begin failures++; $display("FAIL zero_early got=%b exp=0", cur_zero); end
        in_valid = 1'b0;
        @(negedge clk);
        checks++; if (cur_zero !== 1'b1) begin failures++; $display("FAIL zero_sub got=%b exp=1", cur_zero); end
        issue(i_type(5'd0, 5'd0, 16'd7), c_ADDI, s);
        settle();
        instr = r_type(5'd0, 5'd0, 5'd0);
        #1;
        checks++; if (cur_da !== exp_rf[0]) begin failures++; $display("FAIL r0_read got=%0d exp=%0d", cur_da, exp_rf[0]); end
        checks++;
        if (got_q.size() != exp_q.size()) begin failures++; $display("FAIL zero_count got=%0d exp=%0d", got_q.size(), exp_q.size()); end
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            e = exp_q.pop_front(); g = got_q.pop_front(); checks++;
            if (g !== e) begin failures++; $display("FAIL zero_wb got=%0d:%0d exp=%0d:%0d", g[36:32], g[31:0], e[36:32], e[31:0]); end
        end
        exp_q.delete(); got_q.delete();
    endtask

    task automatic test_reset_midflight();
        int s;
        issue(i_type(5'd0, 5'd7, 16'd1), c_ADDI, s);
        issue(i_type(5'd0, 5'd8, 16'd2), c_ADDI, s);
        issue(i_type(5'd0, 5'd9, 16'd3), c_ADDI, s);
        checks++; if (cur_wbv !== 1'b1) begin failures++; $display("FAIL inflight_wb_valid got=%b exp=1", cur_wbv); end
        in_valid = 1'b0;
        rst = 1'b1;
        #1;
        checks++; if (cur_wbv !== 1'b0) begin failures++; $display("FAIL midrst_wb_valid got=%b exp=0", cur_wbv); end
        checks++; if (cur_rdy !== 1'b1) begin failures++; $display("FAIL midrst_in_ready got=%b exp=1", cur_rdy); end
        checks++; if (cur_wbd !== 32'd0) begin failures++; $display("FAIL midrst_wb_data got=%0d exp=0", cur_wbd); end
        @(negedge clk);
        rst = 1'b0;
        model_clear();
        repeat (3) @(negedge clk);
        for (int r = 7; r <= 9; r++) begin
            instr = r_type(5'(r), 5'd0, 5'd0);
            #1;
            checks++; if (cur_da !== exp_rf[r]) begin failures++; $display("FAIL midrst_reg%0d got=%0d exp=%0d", r, cur_da, exp_rf[r]); end
        end
        instr = r_type(5'd1, 5'd0, 5'd0);
        #1;
        checks++; if (cur_da !== exp_rf[1]) begin failures++; $display("FAIL midrst_reg1 got=%0d exp=%0d", cur_da, exp_rf[1]); end
        got_q.delete();
        @(negedge clk);
    endtask

    task automatic test_no_forward();
        int s;
        logic [36:0] e, g;
        sel0 = 1'b1;
        apply_reset();
        issue(i_type(5'd0, 5'd1, 16'd5), c_ADDI, s);
        checks++; if (s !== 0) begin failures++; $display("FAIL nofwd_first stalls=%0d exp=0", s); end
        issue(r_type(5'd1, 5'd1, 5'd2), c_ADD, s);
        checks++; if (s !== 2) begin failures++; $display("FAIL nofwd_stall stalls=%0d exp=2", s); end
        settle();
        checks++;
        if (got_q.size() != exp_q.size()) begin failures++; $display("FAIL nofwd_count got=%0d exp=%0d", got_q.size(), exp_q.size()); end
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            e = exp_q.pop_front(); g = got_q.pop_front(); checks++;
            if (g !== e) begin failures++; $display("FAIL nofwd_wb got=%0d:%0d exp=%0d:%0d", g[36:32], g[31:0], e[36:32], e[31:0]); end
        end
        exp_q.delete(); got_q.delete();
        sel0 = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        sel0 = 1'b0;
        in_valid = 1'b0;
        instr = '0;
        {regdst, regwr, alusrc, memwr, memtoreg, alucntrl} = '0;
        for (int i = 0; i < 64; i++) exp_mem[i] = '0;
        model_clear();
        test_reset();
        test_back_to_back();
        test_store_forward();
        test_load_use();
        test_zero_r0();
        test_reset_midflight();
        test_no_forward();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/datapath_pipe.md
# datapath_pipe

Parametrised five-stage successor to the single-cycle MIPS datapath. It accepts one decoded instruction per cycle under a valid/ready handshake and runs it through ID, EX, MEM and WB pipeline registers. Forwarding and load-use stalls are handled internally, so the forward-select inputs of the previous generation are removed. It sits between the instruction fetch unit and the control decoder, and exports `reg_Da`, `seOut` and `Zero` for branch/jump resolution.

## Interface
- `WIDTH`, 32: datapath and register width; ≥16.
- `NREGS`, 32: register count, power of two; register 0 reads zero.
- `DMEM_DEPTH`, 64: data memory words, power of two.
- `FORWARD`, 1: 1 = EX/MEM and MEM/WB bypass; 0 = stall on every RAW hazard.
- `clk` in 1: clock, rising edge.
- `rst` in 1: reset, asynchronous, active-high.
- `in_valid` in 1: instruction and control fields below are valid.
- `in_ready` out 1: instruction accepted when `in_valid & in_ready` at a rising edge.
- `Instructions` in 32: rs = [25:21], rt = [20:16], rd = [15:11], imm = [15:0]. Only the low log2(NREGS) bits of each register field are used.
- `RegDst`, `RegWr`, `ALUsrc`, `MemWr`, `MemToReg` in 1 each: same meaning as the single-cycle datapath.
- `ALUcntrl` in 2: 00 add, 01 sub, 10 and, 11 or.
- `reg_Da` out WIDTH: rs read data of the presented instruction, after bypass; combinational.
- `seOut` out WIDTH: sign-extended imm of the presented instruction; combinational.
- `Zero` out 1: EX/MEM ALU result == 0, registered.
- `wb_valid` out 1: MEM/WB holds a register-writing instruction.
- `wb_addr` out log2(NREGS): destination register of that instruction.
- `wb_data` out WIDTH: write-back data of that instruction.

## Operation
- Destination register: rd if `RegDst`, else rt. An instruction with destination 0 is never written, forwarded or used for hazard detection.
- ALU operand B: `seOut` if `ALUsrc`, else rt data. Arithmetic wraps modulo 2^WIDTH.
- Data memory word index: ALU result bits [log2(DMEM_DEPTH)+1:2]. Out-of-range addresses wrap.
- Store: synchronous write at the EX/MEM→MEM/WB edge. Load: asynchronous read in MEM.
- Write-back data is the loaded word if `MemToReg`, else the ALU result.
- Forwarding (FORWARD=1): EX operands take the youngest matching source, EX/MEM ALU result before MEM/WB `wb_data`. The same applies to store data.
- The register file bypasses a same-cycle write into ID reads, under either FORWARD setting.
- Load-use stall (FORWARD=1): the ID/EX instruction has `MemToReg & RegWr` and its destination equals a source of the presented instruction.
  - Sources: rs always; rt when `!ALUsrc | MemWr`.
  - Response: `in_ready = 0` and a bubble is inserted into ID/EX.
- FORWARD=0: stall while a presented source matches a writing ID/EX or EX/MEM destination.
- When `in_valid = 0`, a bubble enters ID/EX.
- Bubbles never write the register file or memory.

## Timing
- Accepted at edge k: ID/EX at k, EX/MEM at k+1 (`Zero` valid), MEM/WB at k+2 (`wb_*` valid), register file written at edge k+3.
- Throughput is 1 instruction/cycle with no hazard.
- Load-use costs 1 stall cycle. FORWARD=0 costs up to 2 stall cycles.
- `in_ready` is combinational from pipeline state and the presented fields. It never depends on `in_valid`.
- Reset values:
  - `in_ready` = 1; `wb_valid` = 0; `wb_addr` = 0; `wb_data` = 0; `Zero` = 0.
  - All stage valids = 0; all registers = 0.
  - Data memory is not reset.
- Reset mid-operation squashes all in-flight instructions. No register or memory write occurs on or after the reset-assert edge.
- Simultaneous WB write and ID read of the same register returns the new value.

## Structure
- `datapath_pkg`:
  - `alu_op_e` (ADD, SUB, AND, OR).
  - `ctrl_t` struct: `regdst`, `regwr`, `alusrc`, `aluop`, `memwr`, `memtoreg`.
  - Stage structs `id_ex_t`, `ex_mem_t`, `mem_wb_t`.
- Sub-module `regfile_bypass`: NREGS×WIDTH, 2 read ports, 1 write port, write-through bypass, async reset to zero.
- Hazard and forward logic stays in the top level.

## Test plan
- Reset, then back-to-back with no gaps: addi $1,$0,2015; addi $2,$0,404; add $1,$1,$2 → `wb_data` sequence 2015, 404, 2419; `in_ready` stays 1.
- sw $2,0($0) immediately after the addi writing $2, then lw $3,0($0) → store data is forwarded as 404; `wb_addr` = 3 with `wb_data` = 404.
- lw $3,0($0) followed by add $4,$3,$3 → `in_ready` low for exactly 1 cycle; $4 = 808.
- FORWARD=0, addi $1,$0,5 then add $2,$1,$1 → 2 stall cycles; $2 = 10.
- addi $5,$0,5 then sub $6,$5,$5 → `Zero` = 1 one cycle after the sub is accepted; addi $0,$0,7 → reading $0 returns 0.
- Assert `rst` while 3 instructions are in flight → `wb_valid` = 0 and `in_ready` = 1 immediately; registers read 0 after reset.
